// File: rtl/cicero_pkg.sv
// Shared definitions for the cicero BRAM arbiter: FSM state type and encoding.
package cicero_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bram_arbiter_if.sv
// Load, read-request and read-response bundle between requesters and bram_arbiter.
interface bram_arbiter_if #(
  parameter int unsigned NUM_PORTS        = 4,
  parameter int unsigned READ_WIDTH       = 64,
  parameter int unsigned READ_ADDR_WIDTH  = 9,
  parameter int unsigned WRITE_WIDTH      = 32,
  parameter int unsigned WRITE_ADDR_WIDTH = 10
);

  logic                                       load_start;
  logic                                       load_done;
  logic                                       ld_valid;
  logic [WRITE_ADDR_WIDTH-1:0]                ld_addr;
  logic [WRITE_WIDTH-1:0]                     ld_data;
  logic                                       ld_ready;
  logic [NUM_PORTS-1:0]                       req_valid;
  logic [NUM_PORTS-1:0][READ_ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_PORTS-1:0]                       req_ready;
  logic [NUM_PORTS-1:0]                       rsp_valid;
  logic [READ_WIDTH-1:0]                      rsp_data;
  logic [1:0]                                 state;

  modport master (
    output load_start, load_done, ld_valid, ld_addr, ld_data, req_valid, req_addr,
    input  ld_ready, req_ready, rsp_valid, rsp_data, state
  );

  modport slave (
    input  load_start, load_done, ld_valid, ld_addr, ld_data, req_valid, req_addr,
    output ld_ready, req_ready, rsp_valid, rsp_data, state
  );

endinterface

// File: rtl/bram.sv
// Dual-width RAM: narrow write port for loading, wide asynchronous read port.
module bram #(
  parameter int unsigned READ_WIDTH       = 64,
  parameter int unsigned READ_ADDR_WIDTH  = 9,
  parameter int unsigned WRITE_WIDTH      = 32,
  parameter int unsigned WRITE_ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [WRITE_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WRITE_WIDTH-1:0]      wr_data,
  input  logic [READ_ADDR_WIDTH-1:0]  rd_addr,
  output logic [READ_WIDTH-1:0]       rd_data_c
);

  localparam int unsigned RATIO  = READ_WIDTH / WRITE_WIDTH;
  localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned DEPTH  = 1 << READ_ADDR_WIDTH;

  logic [READ_WIDTH-1:0]      mem [DEPTH];
  logic [READ_ADDR_WIDTH-1:0] wr_row_c;
  logic [LANE_W-1:0]          wr_lane_c;

  // Load word k goes to lane (k mod RATIO) of row (k / RATIO), lane 0 at the LSBs.
  assign wr_row_c  = READ_ADDR_WIDTH'(32'(wr_addr) / RATIO);
  assign wr_lane_c = LANE_W'(32'(wr_addr) % RATIO);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (32'(wr_lane_c) == k) begin
          mem[wr_row_c][k*WRITE_WIDTH +: WRITE_WIDTH] <= wr_data;
        end
      end
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/bram_arbiter.sv
// Load/run FSM with round-robin read arbitration in front of a dual-width BRAM.
module bram_arbiter
  import cicero_pkg::*;
#(
  parameter int unsigned NUM_PORTS        = 4,
  parameter int unsigned READ_WIDTH       = 64,
  parameter int unsigned READ_ADDR_WIDTH  = 9,
  parameter int unsigned WRITE_WIDTH      = 32,
  parameter int unsigned WRITE_ADDR_WIDTH = 10
) (
  input  logic           clk,
  input  logic           rst,
  bram_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NUM_PORTS);

  arb_state_e                 state_q, state_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]       rsp_valid_q, rsp_valid_d;
  logic [READ_WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic [NUM_PORTS-1:0]       gnt_c;
  logic [PTR_W-1:0]           gnt_idx_c;
  logic                       gnt_any_c;
  logic                       wr_en_c;
  logic [READ_ADDR_WIDTH-1:0] rd_addr_c;
  logic [READ_WIDTH-1:0]      rd_data_c;

  // Next state; load_start wins over a simultaneous load_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.load_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (bus.load_start)     state_d = ST_LOAD;
        else if (bus.load_done) state_d = ST_RUN;
      end
      ST_RUN:  if (bus.load_start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-robin: search starts at the port after the last one granted.
  always_comb begin
    int unsigned idx;
    gnt_c     = '0;
    gnt_any_c = 1'b0;
    gnt_idx_c = ptr_q;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = (32'(ptr_q) + i) % NUM_PORTS;
      if (!gnt_any_c && (state_q == ST_RUN) && bus.req_valid[PTR_W'(idx)]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = PTR_W'(idx);
      end
    end
    if (gnt_any_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  always_comb begin
    ptr_d       = gnt_any_c ? gnt_idx_c : ptr_q;
    rsp_valid_d = gnt_c;
    rsp_data_d  = gnt_any_c ? rd_data_c : '0;
  end

  assign wr_en_c   = bus.ld_valid && (state_q == ST_LOAD);
  assign rd_addr_c = bus.req_addr[gnt_idx_c];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_W'(NUM_PORTS - 1);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  bram #(
    .READ_WIDTH       (READ_WIDTH),
    .READ_ADDR_WIDTH  (READ_ADDR_WIDTH),
    .WRITE_WIDTH      (WRITE_WIDTH),
    .WRITE_ADDR_WIDTH (WRITE_ADDR_WIDTH)
  ) u_bram (
    .clk       (clk),
    .wr_en     (wr_en_c),
    .wr_addr   (bus.ld_addr),
    .wr_data   (bus.ld_data),
    .rd_addr   (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  assign bus.ld_ready  = (state_q == ST_LOAD);
  assign bus.req_ready = gnt_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed + randomized bench for bram_arbiter against a word-array reference model.
module tb_bram_arbiter;
  import cicero_pkg::*;

  localparam int unsigned NP  = 4;
  localparam int unsigned RW  = 64;
  localparam int unsigned RAW = 9;
  localparam int unsigned WW  = 32;
  localparam int unsigned WAW = 10;

  logic clk;
  logic rst;

  bram_arbiter_if #(.NUM_PORTS(NP), .READ_WIDTH(RW), .READ_ADDR_WIDTH(RAW),
                    .WRITE_WIDTH(WW), .WRITE_ADDR_WIDTH(WAW)) bus ();

  bram_arbiter #(.NUM_PORTS(NP), .READ_WIDTH(RW), .READ_ADDR_WIDTH(RAW),
                 .WRITE_WIDTH(WW), .WRITE_ADDR_WIDTH(WAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: load-word array, last-granted port, pending response.
  logic [WW-1:0] wmem [1 << WAW];
  arb_state_e    m_state;
  int            m_last;
  logic [NP-1:0] m_rsp_v;
  logic [RW-1:0] m_rsp_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] word_at(input int a);
    return {wmem[2*a+1], wmem[2*a]};
  endfunction

  function automatic logic [NP-1:0][RAW-1:0] rand_ra();
    logic [NP-1:0][RAW-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = RAW'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE;
    m_last  = NP - 1;
    m_rsp_v = '0;
    m_rsp_d = '0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check grant, advance model.
  task automatic cyc(input logic ls, input logic ld, input logic lv,
                     input logic [WAW-1:0] la, input logic [WW-1:0] ldat,
                     input logic [NP-1:0] rv, input logic [NP-1:0][RAW-1:0] ra);
    logic [NP-1:0] eg;
    int            gi;
    logic          found;
    @(negedge clk);
    chk("state", 64'(bus.state), 64'(m_state));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_v));
    if (m_rsp_v != '0) chk("rsp_data", bus.rsp_data, m_rsp_d);
    bus.load_start = ls;
    bus.load_done  = ld;
    bus.ld_valid   = lv;
    bus.ld_addr    = la;
    bus.ld_data    = ldat;
    bus.req_valid  = rv;
    bus.req_addr   = ra;
    #1;
    eg = '0; gi = 0; found = 1'b0;
    if (m_state == ST_RUN && rst) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (!found && rv[p]) begin
          found = 1'b1;
          gi    = p;
          eg[p] = 1'b1;
        end
      end
    end
    chk("req_ready", 64'(bus.req_ready), 64'(eg));
    chk("ld_ready", 64'(bus.ld_ready), 64'(m_state == ST_LOAD));
    if (rst) begin
      if (m_state == ST_LOAD && lv) wmem[la] = ldat;
      m_rsp_v = eg;
      m_rsp_d = '0;
      if (found) begin
        m_rsp_d = word_at(int'(ra[gi]));
        m_last  = gi;
      end
      if (ls)                           m_state = ST_LOAD;
      else if (ld && m_state == ST_LOAD) m_state = ST_RUN;
    end
  endtask

  task automatic idle_cyc(input logic ls, input logic ld);
    cyc(ls, ld, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [NP-1:0][RAW-1:0] ra;
    rst = 1'b0;
    bus.load_start = 1'b0; bus.load_done = 1'b0; bus.ld_valid = 1'b0;
    bus.ld_addr = '0; bus.ld_data = '0; bus.req_valid = '0; bus.req_addr = '0;
    for (int i = 0; i < (1 << WAW); i++) wmem[i] = '0;
    model_reset();
    #1;
    chk("reset_state", 64'(bus.state), 64'(ST_IDLE));
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_data", bus.rsp_data, 64'd0);
    chk("reset_ld_ready", 64'(bus.ld_ready), 64'd0);
    idle_cyc(1'b0, 1'b0);
    rst = 1'b1;

    // Requests in IDLE are never granted
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 4'b1111, rand_ra());

    // Directed load of four words then two reads
    idle_cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 10'd0, 32'h11111111, 4'b0011, rand_ra());
    cyc(1'b0, 1'b0, 1'b1, 10'd1, 32'h22222222, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 10'd2, 32'h33333333, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 10'd3, 32'h44444444, '0, '0);
    idle_cyc(1'b0, 1'b1);
    ra = '0; ra[0] = 9'd0; ra[1] = 9'd1;
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 4'b0011, ra);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 4'b0010, ra);
    idle_cyc(1'b0, 1'b0);

    // Fill whole memory from RUN via load_start, with requests that must be ignored
    idle_cyc(1'b1, 1'b0);
    for (int a = 0; a < (1 << WAW); a++)
      cyc(1'b0, 1'b0, 1'b1, WAW'(a), $urandom, NP'($urandom), rand_ra());
    idle_cyc(1'b0, 1'b1);

    // All ports requesting: strict rotation
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 4'b1111, rand_ra());

    // One port continuously active
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 4'b0100, rand_ra());

    // ld_valid in RUN is ignored; readback of that row follows in the random phase
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b0, 1'b1, WAW'($urandom), $urandom, NP'($urandom), rand_ra());

    // Randomized traffic including mode changes and simultaneous start/done
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
          WAW'($urandom), $urandom, NP'($urandom), rand_ra());

    // load_start with load_done in RUN: grant still answered, state goes LOAD
    idle_cyc(1'b1, 1'b0);
    idle_cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 4'b0100, rand_ra());
    idle_cyc(1'b0, 1'b1);

    // Reset mid-RUN with a grant in flight
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 4'b1111, rand_ra());
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 4'b1111, rand_ra());
    #2 rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_state", 64'(bus.state), 64'(ST_IDLE));
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 4'b1111, rand_ra());
    rst = 1'b1;

    // Memory survives reset
    idle_cyc(1'b1, 1'b0);
    idle_cyc(1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 1'b0, 1'b0, '0, '0, NP'($urandom), rand_ra());
    idle_cyc(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter READ_WIDTH, default 64, read data width.
REQ-003 SHALL have parameter READ_ADDR_WIDTH, default 9, read word address width.
REQ-004 SHALL have parameter WRITE_WIDTH, default 32, load data width.
REQ-005 SHALL have parameter WRITE_ADDR_WIDTH, default 10, load word address width.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 load_start  in  1  pulse: enter LOAD state.
REQ-009 load_done  in  1  pulse: leave LOAD, enter RUN.
REQ-010 ld_valid  in  1  load write strobe.
REQ-011 ld_addr  in  WRITE_ADDR_WIDTH  load write address.
REQ-012 ld_data  in  WRITE_WIDTH  load write data.
REQ-013 ld_ready  out  1  load write accepted this cycle.
REQ-014 req_valid  in  NUM_PORTS  per-requester read request.
REQ-015 req_addr  in  NUM_PORTS x READ_ADDR_WIDTH  per-requester read address.
REQ-016 req_ready  out  NUM_PORTS  one-hot grant; at most one bit high.
REQ-017 rsp_valid  out  NUM_PORTS  one-hot read response strobe.
REQ-018 rsp_data  out  READ_WIDTH  shared read data, meaningful only when rsp_valid nonzero.
REQ-019 state  out  2  current FSM state, for status.

Function
REQ-020 FSM SHALL have states IDLE, LOAD, RUN; reset state IDLE.
REQ-021 IDLE->LOAD on load_start; LOAD->RUN on load_done; RUN->LOAD on load_start; all other cases hold.
REQ-022 load_start and load_done in the same cycle SHALL be resolved as load_start (go/stay LOAD).
REQ-023 ld_ready SHALL equal (state==LOAD) combinationally; writes with ld_valid&ld_ready SHALL pass to the memory write port the same cycle.
REQ-024 ld_valid outside LOAD SHALL be ignored; memory contents unchanged.
REQ-025 req_ready SHALL be all-zero unless state==RUN.
REQ-026 In RUN, grant SHALL be round-robin: highest priority is the port after the last granted port, wrapping NUM_PORTS-1 -> 0; after reset the pointer favours port 0.
REQ-027 A grant SHALL be combinational from req_valid and the pointer; the pointer SHALL update only on a granted cycle.
REQ-028 Granted address SHALL drive the memory read port the same cycle; one read per cycle, full throughput.
REQ-029 Read latency SHALL be exactly 1 cycle: grant to port i in cycle t -> rsp_valid[i]=1 in t+1 with rsp_data = word at that address.
REQ-030 Responses SHALL have no backpressure; requesters must sample in the response cycle.
REQ-031 A grant issued in the last RUN cycle before RUN->LOAD SHALL still produce its response in the next cycle.
REQ-032 With one requester continuously active, it SHALL be granted every cycle; with all active, each SHALL be granted once per NUM_PORTS cycles.
REQ-033 READ_WIDTH SHALL be an integer multiple of WRITE_WIDTH, and read address space times the ratio SHALL equal write address space; load word k lands in slice k mod ratio of read word k/ratio, lowest slice at LSBs.

Reset
REQ-034 On rst low: state=IDLE, rr pointer=NUM_PORTS-1, rsp_valid=0, rsp_data=0, req_ready=0, ld_ready=0, asynchronously and immediately.
REQ-035 Memory contents SHALL NOT be cleared by reset; a response pending at reset SHALL be dropped.

Structure
REQ-036 State enum and state encoding SHALL live in the shared cicero package.
REQ-037 The dual-width block RAM SHALL be one instantiated sub-module, bram, with matching parameters; arbitration, FSM and response register stay in bram_arbiter.

Verification
REQ-038 Load 4 words 0x11111111,0x22222222,0x33333333,0x44444444 at ld_addr 0..3, load_done, port 0 reads addr 0 and port 1 reads addr 1 -> rsp_data 0x2222222211111111 with rsp_valid=0001, then 0x4444444433333333 with rsp_valid=0010.
REQ-039 All 4 ports request every cycle in RUN for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each rsp_valid exactly 1 cycle after its grant.
REQ-040 Requests while in IDLE or LOAD -> req_ready=0 throughout; ld_valid in RUN -> ld_ready=0, memory unchanged on readback.
REQ-041 load_start and load_done same cycle in RUN -> state LOAD next cycle; grant issued that cycle still returns rsp_valid next cycle.
REQ-042 rst asserted mid-RUN with a grant in flight -> rsp_valid=0 immediately, state IDLE, no response emitted; memory contents unchanged on re-entry to RUN.
